// File: rtl/imem_stream_loader_if.sv
// Byte-stream handshake into the instruction-memory loader.
// The master drives valid/data/last. The loader (slave) returns ready.
interface imem_stream_loader_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_last;
    logic       in_ready;

    modport master (
        output in_valid,
        output in_data,
        output in_last,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_last,
        output in_ready
    );
endinterface

// File: rtl/imem_stream_loader.sv
// Boot loader: packs a byte stream little-endian into 32-bit words and writes them to IMEM.
// It holds the MIPS core in reset until the image is in place plus a hold window.
module imem_stream_loader #(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  res,
    imem_stream_loader_if.slave   strm,
    input  logic                  reload,
    output logic                  imem_we,
    output logic [ADDR_W-1:0]     imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  cpu_res,
    output logic                  load_done,
    output logic [ADDR_W:0]       word_count,
    output logic                  overflow
);

    typedef enum logic [1:0] {
        S_LOAD,
        S_HOLD,
        S_RUN
    } state_t;

    localparam int unsigned       HOLD_W    = $clog2(HOLD_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [ADDR_W:0]   WC_ONE    = (ADDR_W + 1)'(1);

    state_t              state_q;
    logic                in_ready_q;
    logic                imem_we_q;
    logic [ADDR_W-1:0]   imem_addr_q;
    logic [31:0]         imem_wdata_q;
    logic                cpu_res_q;
    logic                load_done_q;
    logic [ADDR_W:0]     word_count_q;
    logic                overflow_q;
    logic [1:0]          byte_idx_q;
    logic [31:0]         shift_q;
    logic [HOLD_W-1:0]   hold_cnt_q;

    logic                xfer;
    logic                full;
    logic                word_done;
    logic [31:0]         word_d;

    // Upper bytes of shift_q are always zero, so a flushed partial word is zero-filled for free.
    always_comb begin
        xfer      = strm.in_valid & in_ready_q;
        full      = word_count_q[ADDR_W];
        word_done = (byte_idx_q == 2'd3) | strm.in_last;
        word_d    = shift_q | ({24'b0, strm.in_data} << {byte_idx_q, 3'b000});
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q      <= S_LOAD;
            in_ready_q   <= 1'b1;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            cpu_res_q    <= 1'b1;
            load_done_q  <= 1'b0;
            word_count_q <= '0;
            overflow_q   <= 1'b0;
            byte_idx_q   <= '0;
            shift_q      <= '0;
            hold_cnt_q   <= '0;
        end else begin
            imem_we_q <= 1'b0;
            case (state_q)
                S_LOAD: begin
                    if (xfer) begin
                        if (full) begin
                            overflow_q <= 1'b1;
                        end else if (word_done) begin
                            imem_we_q    <= 1'b1;
                            imem_addr_q  <= word_count_q[ADDR_W-1:0];
                            imem_wdata_q <= word_d;
                            word_count_q <= word_count_q + WC_ONE;
                            byte_idx_q   <= '0;
                            shift_q      <= '0;
                        end else begin
                            shift_q    <= word_d;
                            byte_idx_q <= byte_idx_q + 2'd1;
                        end
                        // The final write (if any) lands in the first HOLD cycle.
                        if (strm.in_last) begin
                            state_q    <= S_HOLD;
                            in_ready_q <= 1'b0;
                            hold_cnt_q <= '0;
                            byte_idx_q <= '0;
                            shift_q    <= '0;
                        end
                    end
                end
                S_HOLD: begin
                    if (hold_cnt_q == HOLD_LAST) begin
                        state_q     <= S_RUN;
                        cpu_res_q   <= 1'b0;
                        load_done_q <= 1'b1;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + HOLD_ONE;
                    end
                end
                S_RUN: begin
                    if (reload) begin
                        state_q      <= S_LOAD;
                        in_ready_q   <= 1'b1;
                        cpu_res_q    <= 1'b1;
                        load_done_q  <= 1'b0;
                        word_count_q <= '0;
                        overflow_q   <= 1'b0;
                        byte_idx_q   <= '0;
                        shift_q      <= '0;
                    end
                end
                default: begin
                    state_q <= S_LOAD;
                end
            endcase
        end
    end

    assign strm.in_ready = in_ready_q;
    assign imem_we       = imem_we_q;
    assign imem_addr     = imem_addr_q;
    assign imem_wdata    = imem_wdata_q;
    assign cpu_res       = cpu_res_q;
    assign load_done     = load_done_q;
    assign word_count    = word_count_q;
    assign overflow      = overflow_q;

endmodule

// File: tb/tb_imem_stream_loader.sv
// Randomized bench for imem_stream_loader: two instances (256-word and 4-word IMEM) share one stream
// and are checked against an image-level model of the expected writes, counts and overflow.
module tb_imem_stream_loader;

    localparam int unsigned HOLD = 4;
    localparam int unsigned AW_A = 8;
    localparam int unsigned AW_B = 2;

    logic clk = 1'b0;
    logic res;
    logic reload;
    logic v, l;
    logic [7:0] d;

    imem_stream_loader_if sa ();
    imem_stream_loader_if sb ();

    assign sa.in_valid = v;
    assign sa.in_data  = d;
    assign sa.in_last  = l;
    assign sb.in_valid = v;
    assign sb.in_data  = d;
    assign sb.in_last  = l;

    logic              we_a, we_b;
    logic [AW_A-1:0]   addr_a;
    logic [AW_B-1:0]   addr_b;
    logic [31:0]       wdata_a, wdata_b;
    logic              cres_a, cres_b, done_a, done_b, ovf_a, ovf_b;
    logic [AW_A:0]     wc_a;
    logic [AW_B:0]     wc_b;

    imem_stream_loader #(.ADDR_W(AW_A), .HOLD_CYCLES(HOLD)) dut_a (
        .clk(clk), .res(res), .strm(sa.slave), .reload(reload),
        .imem_we(we_a), .imem_addr(addr_a), .imem_wdata(wdata_a),
        .cpu_res(cres_a), .load_done(done_a), .word_count(wc_a), .overflow(ovf_a)
    );

    imem_stream_loader #(.ADDR_W(AW_B), .HOLD_CYCLES(HOLD)) dut_b (
        .clk(clk), .res(res), .strm(sb.slave), .reload(reload),
        .imem_we(we_b), .imem_addr(addr_b), .imem_wdata(wdata_b),
        .cpu_res(cres_b), .load_done(done_b), .word_count(wc_b), .overflow(ovf_b)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Write log: {addr (zero-extended to 8 bits), data}
    logic [39:0] wr_a[$];
    logic [39:0] wr_b[$];

    always @(negedge clk) begin
        if (we_a) wr_a.push_back({addr_a, wdata_a});
        if (we_b) wr_b.push_back({6'b0, addr_b, wdata_b});
    end

    // Image currently being streamed
    logic [7:0] img[$];

    function automatic logic [31:0] model_word(input int i);
        logic [31:0] w = '0;
        for (int k = 0; k < 4; k++)
            if (4 * i + k < img.size()) w[8*k +: 8] = img[4 * i + k];
        return w;
    endfunction

    task automatic check_dut(input string tag, input int aw, input logic [39:0] wq[$],
                             input int wc, input logic ovf);
        int n   = img.size();
        int nw  = (n + 3) / 4;
        int cap = 1 << aw;
        int exp_w = (nw < cap) ? nw : cap;
        check({tag, "_nwr"}, wq.size(), exp_w);
        for (int i = 0; i < exp_w && i < wq.size(); i++) begin
            check($sformatf("%s_addr%0d", tag, i), wq[i][39:32], i);
            check($sformatf("%s_data%0d", tag, i), wq[i][31:0], model_word(i));
        end
        check({tag, "_wcnt"}, wc, exp_w);
        check({tag, "_ovf"}, ovf, (n > 4 * cap));
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_rdy_a"}, sa.in_ready, 1);
        check({tag, "_rdy_b"}, sb.in_ready, 1);
        check({tag, "_we"}, {we_a, we_b}, 0);
        check({tag, "_addr"}, {addr_a, addr_b}, 0);
        check({tag, "_wdata"}, {wdata_a, wdata_b}, 0);
        check({tag, "_cres"}, {cres_a, cres_b}, 2'b11);
        check({tag, "_done"}, {done_a, done_b}, 0);
        check({tag, "_wc"}, {wc_a, wc_b}, 0);
        check({tag, "_ovf"}, {ovf_a, ovf_b}, 0);
    endtask

    // Called at posedge+1; returns at posedge+1 after the transfer edge.
    task automatic push_byte(input logic [7:0] b, input logic last);
        v = 1'b1;
        d = b;
        l = last;
        @(negedge clk);
        check("load_rdy", {sa.in_ready, sb.in_ready}, 2'b11);
        @(posedge clk);
        #1;
        v = 1'b0;
        l = 1'b0;
    endtask

    task automatic send_image(input string tag, input int max_gap, input bit reload_in_hold);
        int  hold_n = 0;
        bit  rel = 0;
        wr_a.delete();
        wr_b.delete();
        foreach (img[i]) begin
            repeat ($urandom_range(max_gap, 0)) begin
                @(posedge clk);
                #1;
            end
            push_byte(img[i], (i == img.size() - 1));
        end
        for (int c = 0; c < 50 && !rel; c++) begin
            @(negedge clk);
            reload = (reload_in_hold && c == 1);
            if (cres_a) begin
                hold_n++;
                if (c == 0) check({tag, "_hold_rdy"}, {sa.in_ready, sb.in_ready}, 0);
            end else begin
                rel = 1;
            end
        end
        reload = 1'b0;
        check({tag, "_released"}, rel, 1);
        check({tag, "_hold_len"}, hold_n, HOLD);
        check({tag, "_cres_b"}, cres_b, 0);
        check({tag, "_done"}, {done_a, done_b}, 2'b11);
        check({tag, "_run_rdy"}, {sa.in_ready, sb.in_ready}, 0);
        check_dut({tag, "_A"}, AW_A, wr_a, int'(wc_a), ovf_a);
        check_dut({tag, "_B"}, AW_B, wr_b, int'(wc_b), ovf_b);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reload(input string tag);
        reload = 1'b1;
        @(posedge clk);
        #1;
        reload = 1'b0;
        check({tag, "_cres"}, {cres_a, cres_b}, 2'b11);
        check({tag, "_done"}, {done_a, done_b}, 0);
        check({tag, "_rdy"}, {sa.in_ready, sb.in_ready}, 2'b11);
        check({tag, "_wc"}, {wc_a, wc_b}, 0);
        check({tag, "_ovf"}, {ovf_a, ovf_b}, 0);
    endtask

    task automatic rand_image(input int n);
        img.delete();
        for (int i = 0; i < n; i++) img.push_back(8'($urandom));
    endtask

    task automatic async_reset(input string tag);
        #2;
        res = 1'b0;
        #1;
        check_reset(tag);
        @(negedge clk);
        res = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        res = 1'b0;
        reload = 1'b0;
        v = 1'b0;
        l = 1'b0;
        d = '0;
        #12;
        check_reset("por");
        @(negedge clk);
        res = 1'b1;
        @(posedge clk);
        #1;

        img = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        send_image("seq8", 0, 0);

        // Stream activity in RUN must be ignored
        wr_a.delete();
        wr_b.delete();
        v = 1'b1; d = 8'h5A; l = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        v = 1'b0; l = 1'b0;
        check("run_ign_wr", wr_a.size() + wr_b.size(), 0);
        check("run_ign_state", {cres_a, done_a, sa.in_ready}, 3'b010);

        do_reload("rl1");
        img = {8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};
        send_image("part6", 0, 0);

        do_reload("rl2");
        send_image("part6_gap", 3, 0);

        do_reload("rl3");
        rand_image(20);
        send_image("ovf20", 2, 0);

        do_reload("rl4");
        img = {8'h10, 8'h20, 8'h30, 8'h40};
        send_image("one_word", 0, 0);

        for (int k = 0; k < 4; k++) begin
            do_reload($sformatf("rlr%0d", k));
            rand_image($urandom_range(24, 1));
            send_image($sformatf("rnd%0d", k), 3, k[0]);
        end

        // Async reset after two bytes of a word
        do_reload("rl5");
        push_byte(8'hE1, 1'b0);
        push_byte(8'hE2, 1'b0);
        async_reset("rst_word");
        img = {8'h31, 8'h32, 8'h33, 8'h34};
        send_image("after_rst_word", 1, 0);

        // Async reset during HOLD
        do_reload("rl6");
        rand_image(5);
        foreach (img[i]) push_byte(img[i], (i == img.size() - 1));
        @(posedge clk);
        #1;
        async_reset("rst_hold");
        img = {8'h71, 8'h72, 8'h73};
        send_image("after_rst_hold", 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_stream_loader.md
Name: imem_stream_loader

Overview:
- Boot-time instruction-memory writer for the pipelined MIPS core.
- Accepts a byte stream over a valid/ready interface and packs the bytes little-endian into 32-bit words.
- Writes the words to consecutive instruction-memory addresses.
- Holds the core in reset until loading completes, then releases it. Supports reload on request.

Parameters:
ADDR_W, 8, instruction-memory word-address width; capacity 2^ADDR_W words
HOLD_CYCLES, 4, cycles the core's reset stays asserted after the final write; minimum 1

Ports:
clk  input  1  system clock, rising edge
res  input  1  reset, asynchronous, active-low
in_valid  input  1  stream byte valid
in_data  input  8  stream byte
in_last  input  1  final byte of image; qualified by in_valid
in_ready  output  1  loader can accept a byte
reload  input  1  single-cycle pulse; restarts loading, honoured only in RUN
imem_we  output  1  instruction-memory write strobe, one cycle per word
imem_addr  output  ADDR_W  word address of the write
imem_wdata  output  32  word data of the write
cpu_res  output  1  active-high reset to the MIPS core
load_done  output  1  high in RUN
word_count  output  ADDR_W+1  words written in the current load
overflow  output  1  sticky; image exceeded capacity

Behaviour:
- Async reset (res=0) takes effect immediately, including mid-load or mid-hold:
  - state=LOAD, in_ready=1, imem_we=0, imem_addr=0, imem_wdata=0.
  - cpu_res=1, load_done=0, word_count=0, overflow=0.
  - byte index=0, byte shift register cleared.
- A byte transfers on a rising edge with in_valid & in_ready. All outputs are registered.
- States: LOAD -> HOLD -> RUN; RUN -> LOAD on reload.
- LOAD:
  - in_ready=1, cpu_res=1.
  - Byte k (k=0..3) fills wdata bits [8k+7:8k].
  - On the transfer of byte 3, imem_we=1 in the following cycle, with imem_addr=current address and imem_wdata=packed word. After that the address increments by 1 and word_count increments by 1.
  - Back-to-back transfers every cycle are legal. in_ready never drops during LOAD.
  - in_last on byte k<3 flushes a partial word: the upper bytes are zero-filled and it is written the same way as a full word.
  - in_last on byte 3 produces only the normal write; there is no extra empty word.
  - After the in_last write, the next state is HOLD; the first HOLD cycle coincides with the imem_we cycle.
  - in_valid=0 between bytes: no state change, and the partial word is retained indefinitely.
- Capacity:
  - word_count reaching 2^ADDR_W means memory is full.
  - Any byte accepted after that sets overflow=1 and is discarded: no write and no wrap of imem_addr.
  - in_ready stays 1 so the stream can drain. in_last still moves the loader to HOLD.
  - overflow clears only on reset or reload.
- HOLD:
  - in_ready=0, cpu_res=1.
  - A counter counts HOLD_CYCLES clock cycles, then the next state is RUN.
- RUN:
  - cpu_res=0, load_done=1, in_ready=0.
  - Stream inputs are ignored.
  - reload=1 on an edge returns to LOAD:
    - cpu_res=1 and load_done=0 on the next cycle.
    - address, word_count, overflow and byte index are cleared.
  - reload outside RUN is ignored.
- imem_we is never asserted outside the cycle after a word completes.
- imem_addr and imem_wdata hold their last values when imem_we=0.

Test Plan:
- Reset release, then 8 bytes 0x01..0x08 back-to-back with in_last on 0x08 -> imem_we pulses at addr 0 with data 0x04030201, then addr 1 with data 0x08070605. word_count=2. cpu_res falls exactly HOLD_CYCLES=4 cycles after the HOLD entry, and load_done rises at the same time.
- 6 bytes 0xAA,0xBB,0xCC,0xDD,0x11,0x22 with in_last on 0x22 -> writes 0xDDCCBBAA at addr 0 and 0x00002211 at addr 1. word_count=2.
- Same stream with random in_valid gaps of 0-3 cycles -> identical writes and addresses; in_ready stays 1 throughout LOAD.
- ADDR_W=2, 20 bytes with in_last on byte 20 -> 4 writes (addr 0-3), no write for bytes 17-20, no address wrap. overflow=1, word_count=4, core released after the hold.
- In RUN, pulse reload, then 4 bytes 0x10,0x20,0x30,0x40 with in_last -> cpu_res=1 the cycle after reload. Write 0x40302010 at addr 0, word_count=1, overflow=0, then release.
- Assert res=0 asynchronously mid-word (after 2 bytes) and mid-HOLD -> outputs go to reset values without waiting for a clock edge. The next stream starts at byte 0 / addr 0, and no stale byte appears in the next word.
